// File: rtl/ir_pkg.sv
// Shared types for the NEC key-event controller: event codes, FSM states and
// the event word width helper.
package ir_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'b01,
    EVT_HOLD    = 2'b10,
    EVT_RELEASE = 2'b11
  } evt_type_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_PRESSED = 2'b01,
    ST_SWITCH  = 2'b10
  } state_e;

  localparam int EVT_TYPE_W = 2;

  // Event word is {type, address, command}.
  function automatic int evt_width(input int data_width);
    return EVT_TYPE_W + 2 * data_width;
  endfunction

endpackage

// File: rtl/ir_evt_fifo.sv
// First-word fall-through event buffer with registered pointers.
// DEPTH must be a power of two, at least 2.
module ir_evt_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit separates full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ir_key_ctrl.sv
// Validates decoded NEC frames, tracks the held key across repeat codes with a
// release timeout, and emits PRESS/HOLD/RELEASE events through a small buffer.
module ir_key_ctrl
  import ir_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int TIMEOUT_CYC = 120000,
  parameter int HOLD_EVERY  = 4,
  parameter int STRICT_ADDR = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_repeat,
  input  logic [4*DATA_WIDTH-1:0]   i_frame,
  output logic                      o_evt_valid,
  input  logic                      i_evt_ready,
  output logic [2+2*DATA_WIDTH-1:0] o_evt_data,
  output logic                      o_key_down,
  output logic [7:0]                o_err_cnt,
  output logic [7:0]                o_drop_cnt,
  output state_e                    o_dbg_state
);

  localparam int EW = evt_width(DATA_WIDTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int RW = $clog2(HOLD_EVERY + 1);

  state_e                state;
  logic [DATA_WIDTH-1:0] key_addr, key_cmd;
  logic [TW-1:0]         timer;
  logic [RW-1:0]         rep_cnt;
  logic [7:0]            err_cnt, drop_cnt;

  logic [DATA_WIDTH-1:0] f_addr, f_addr_bar, f_cmd, f_cmd_bar;
  logic frame_ok, take_frame, bad_frame, rep_evt, timeout, hold_due;

  assign {f_cmd_bar, f_cmd, f_addr_bar, f_addr} = i_frame;

  assign frame_ok   = (f_cmd_bar == ~f_cmd) &&
                      ((STRICT_ADDR == 0) || (f_addr_bar == ~f_addr));
  assign take_frame = i_valid && frame_ok;
  assign bad_frame  = i_valid && !frame_ok && (state != ST_SWITCH);
  // A frame in the same cycle swallows the repeat pulse.
  assign rep_evt    = i_repeat && !i_valid;
  assign timeout    = (timer == TW'(TIMEOUT_CYC - 1));
  assign hold_due   = (rep_cnt == RW'(HOLD_EVERY - 1));

  logic                  push;
  evt_type_e             push_type;
  logic [DATA_WIDTH-1:0] push_addr, push_cmd;
  logic [EW-1:0]         push_data;
  logic                  fifo_full, fifo_empty, evt_pop;

  always_comb begin
    push      = 1'b0;
    push_type = EVT_PRESS;
    push_addr = key_addr;
    push_cmd  = key_cmd;
    case (state)
      ST_IDLE: begin
        if (take_frame) begin
          push      = 1'b1;
          push_addr = f_addr;
          push_cmd  = f_cmd;
        end
      end
      ST_PRESSED: begin
        if (take_frame) begin
          push      = 1'b1;
          push_type = EVT_RELEASE;
        end else if (rep_evt) begin
          push      = hold_due;
          push_type = EVT_HOLD;
        end else if (timeout) begin
          push      = 1'b1;
          push_type = EVT_RELEASE;
        end
      end
      ST_SWITCH: push = 1'b1;
      default: ;
    endcase
  end

  assign push_data = {push_type, push_addr, push_cmd};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      key_addr   <= '0;
      key_cmd    <= '0;
      timer      <= '0;
      rep_cnt    <= '0;
      o_key_down <= 1'b0;
      err_cnt    <= '0;
    end else begin
      if (bad_frame && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      case (state)
        ST_IDLE: begin
          if (take_frame) begin
            key_addr   <= f_addr;
            key_cmd    <= f_cmd;
            timer      <= '0;
            rep_cnt    <= '0;
            o_key_down <= 1'b1;
            state      <= ST_PRESSED;
          end
        end
        ST_PRESSED: begin
          if (take_frame) begin
            key_addr <= f_addr;
            key_cmd  <= f_cmd;
            state    <= ST_SWITCH;
          end else if (rep_evt) begin
            timer   <= '0;
            rep_cnt <= hold_due ? '0 : rep_cnt + RW'(1);
          end else if (timeout) begin
            o_key_down <= 1'b0;
            state      <= ST_IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        ST_SWITCH: begin
          timer   <= '0;
          rep_cnt <= '0;
          state   <= ST_PRESSED;
        end
        default: begin
          o_key_down <= 1'b0;
          state      <= ST_IDLE;
        end
      endcase
    end
  end

  // Events are lost, not back-pressured: the FSM keeps moving when the buffer is full.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) drop_cnt <= '0;
    else if (push && fifo_full && !evt_pop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  // Stream handshake: an event transfers on a rising edge where o_evt_valid and
  // i_evt_ready are both high; while valid is high and ready low, o_evt_data holds.
  ir_evt_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (i_evt_ready),
    .pop_data  (o_evt_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign o_evt_valid = !fifo_empty;
  assign evt_pop     = o_evt_valid && i_evt_ready;
  assign o_err_cnt   = err_cnt;
  assign o_drop_cnt  = drop_cnt;
  assign o_dbg_state = state;

endmodule

// File: tb/tb_ir_key_ctrl.sv
// Bench for ir_key_ctrl: strict and extended-address instances share stimulus and
// are compared every cycle against an event-level reference model.
module tb_ir_key_ctrl;
  import ir_pkg::*;

  localparam int DW    = 8;
  localparam int EW    = 2 + 2 * DW;
  localparam int TO    = 200;
  localparam int HE    = 4;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        i_valid = 1'b0;
  logic        i_repeat = 1'b0;
  logic        i_evt_ready = 1'b0;
  logic [31:0] i_frame = '0;

  logic [1:0]    evt_valid;
  logic [1:0]    key_down;
  logic [EW-1:0] evt_data [2];
  logic [7:0]    err_cnt [2];
  logic [7:0]    drop_cnt [2];
  state_e        dbg_state [2];

  ir_key_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYC(TO), .HOLD_EVERY(HE),
                .STRICT_ADDR(1), .FIFO_DEPTH(DEPTH)) u_dut_s (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_repeat(i_repeat), .i_frame(i_frame),
    .o_evt_valid(evt_valid[0]), .i_evt_ready(i_evt_ready), .o_evt_data(evt_data[0]),
    .o_key_down(key_down[0]), .o_err_cnt(err_cnt[0]), .o_drop_cnt(drop_cnt[0]),
    .o_dbg_state(dbg_state[0]));

  ir_key_ctrl #(.DATA_WIDTH(DW), .TIMEOUT_CYC(TO), .HOLD_EVERY(HE),
                .STRICT_ADDR(0), .FIFO_DEPTH(DEPTH)) u_dut_x (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_repeat(i_repeat), .i_frame(i_frame),
    .o_evt_valid(evt_valid[1]), .i_evt_ready(i_evt_ready), .o_evt_data(evt_data[1]),
    .o_key_down(key_down[1]), .o_err_cnt(err_cnt[1]), .o_drop_cnt(drop_cnt[1]),
    .o_dbg_state(dbg_state[1]));

  // ---------------- scoreboard / checking ----------------
  int n_total = 0;
  int n_bad   = 0;
  int hold_seen = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];

  function automatic int q_size(input int d);
    return (d == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic logic [EW-1:0] q_front(input int d);
    if (d == 0) return exp_q0[0];
    return exp_q1[0];
  endfunction

  task automatic q_pop(input int d);
    if (d == 0) void'(exp_q0.pop_front());
    else        void'(exp_q1.pop_front());
  endtask

  task automatic q_push(input int d, input logic [EW-1:0] e);
    if (d == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // ---------------- reference model ----------------
  bit         strict_of [2];
  bit         m_down [2];
  bit         m_sw [2];
  logic [7:0] m_addr [2];
  logic [7:0] m_cmd [2];
  int         m_reps [2];
  int         m_last [2];
  int         m_err [2];
  int         m_drop [2];
  int         cyc = 0;

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_down[d] = 0; m_sw[d] = 0; m_addr[d] = '0; m_cmd[d] = '0;
      m_reps[d] = 0; m_last[d] = 0; m_err[d] = 0; m_drop[d] = 0;
    end
    exp_q0.delete();
    exp_q1.delete();
  endtask

  // One clock edge of key tracking plus the bounded event buffer.
  task automatic model_step(input int d, input bit v, input bit r,
                            input logic [31:0] f, input bit rdy);
    bit ok, push, pop, full;
    logic [EW-1:0] ev;
    ok = (f[31:24] == ~f[23:16]) && (!strict_of[d] || (f[15:8] == ~f[7:0]));
    push = 0;
    ev = '0;
    if (m_sw[d]) begin
      push = 1; ev = {2'b01, m_addr[d], m_cmd[d]};
      m_sw[d] = 0; m_last[d] = cyc; m_reps[d] = 0;
    end else begin
      if (v && !ok && m_err[d] < 255) m_err[d]++;
      if (!m_down[d]) begin
        if (v && ok) begin
          m_addr[d] = f[7:0]; m_cmd[d] = f[23:16];
          push = 1; ev = {2'b01, f[7:0], f[23:16]};
          m_down[d] = 1; m_last[d] = cyc; m_reps[d] = 0;
        end
      end else if (v && ok) begin
        push = 1; ev = {2'b11, m_addr[d], m_cmd[d]};
        m_addr[d] = f[7:0]; m_cmd[d] = f[23:16];
        m_sw[d] = 1;
      end else if (r && !v) begin
        m_last[d] = cyc;
        m_reps[d]++;
        if (m_reps[d] == HE) begin
          push = 1; ev = {2'b10, m_addr[d], m_cmd[d]};
          m_reps[d] = 0;
        end
      end else if (cyc - m_last[d] == TO) begin
        push = 1; ev = {2'b11, m_addr[d], m_cmd[d]};
        m_down[d] = 0;
      end
    end
    pop  = (q_size(d) > 0) && rdy;
    full = (q_size(d) == DEPTH);
    if (pop) q_pop(d);
    if (push) begin
      if (full && !pop) begin
        if (m_drop[d] < 255) m_drop[d]++;
      end else begin
        q_push(d, ev);
      end
    end
  endtask

  task automatic compare_all();
    for (int d = 0; d < 2; d++) begin
      logic [EW-1:0] exp_data;
      state_e exp_st;
      exp_data = (q_size(d) > 0) ? q_front(d) : '0;
      exp_st = m_sw[d] ? ST_SWITCH : (m_down[d] ? ST_PRESSED : ST_IDLE);
      chk($sformatf("evt_valid[%0d]", d), 32'(evt_valid[d]), 32'(q_size(d) > 0));
      chk($sformatf("evt_data[%0d]", d), 32'(evt_data[d]), 32'(exp_data));
      chk($sformatf("key_down[%0d]", d), 32'(key_down[d]), 32'(m_down[d]));
      chk($sformatf("err_cnt[%0d]", d), 32'(err_cnt[d]), m_err[d]);
      chk($sformatf("drop_cnt[%0d]", d), 32'(drop_cnt[d]), m_drop[d]);
      chk($sformatf("state[%0d]", d), 32'(dbg_state[d]), 32'(exp_st));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called at a falling edge: check outputs, drive the next cycle, advance model.
  task automatic step(input bit v, input bit r, input logic [31:0] f, input bit rdy);
    compare_all();
    i_valid = v; i_repeat = r; i_frame = f; i_evt_ready = rdy;
    if (evt_valid[0] && rdy && evt_data[0][EW-1:EW-2] == 2'b10) hold_seen++;
    for (int d = 0; d < 2; d++) model_step(d, v, r, f, rdy);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, '0, rdy);
  endtask

  function automatic logic [31:0] mk(input logic [7:0] a, input logic [7:0] c);
    return {~c, c, ~a, a};
  endfunction

  task automatic rand_phase(input int n, input int pv, input int pr, input int prdy);
    for (int i = 0; i < n; i++) begin
      bit v, r, rdy;
      logic [31:0] f;
      int k;
      v   = ($urandom_range(0, 999) < pv);
      r   = ($urandom_range(0, 999) < pr);
      rdy = ($urandom_range(0, 99) < prdy);
      f   = mk(8'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      k   = $urandom_range(0, 9);
      if (k == 0)      f[31:24] = f[31:24] ^ 8'h01;
      else if (k == 1) f[15:8]  = 8'($urandom_range(0, 255));
      step(v, r, f, rdy);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    strict_of[0] = 1;
    strict_of[1] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    rst = 1'b0;

    // Press, then release after the full timeout with no activity.
    step(1, 0, mk(8'h01, 8'h10), 1);
    chk("press_evt", 32'(evt_data[0]), 32'({2'b01, 8'h01, 8'h10}));
    idle(TO - 1, 1);
    chk("no_early_release", 32'(evt_valid[0]), 32'd0);
    idle(1, 1);
    chk("release_evt", 32'(evt_data[0]), 32'({2'b11, 8'h01, 8'h10}));
    idle(3, 1);
    chk("release_keydown", 32'(key_down[0]), 32'd0);

    // Eight repeats give two HOLDs; release is timed from the last repeat.
    hold_seen = 0;
    step(1, 0, mk(8'h01, 8'h10), 1);
    for (int i = 0; i < 8; i++) begin
      idle(29, 1);
      step(0, 1, '0, 1);
    end
    idle(3, 1);
    chk("hold_count", 32'(hold_seen), 32'd2);
    idle(TO - 4, 1);
    chk("held_no_release", 32'(evt_valid[0]), 32'd0);
    chk("held_keydown", 32'(key_down[0]), 32'd1);
    idle(1, 1);
    chk("hold_release_evt", 32'(evt_data[0]), 32'({2'b11, 8'h01, 8'h10}));
    idle(3, 1);

    // Bad command inverse, then an extended address on both instances.
    step(1, 0, {8'h00, 8'h10, 8'hFE, 8'h01}, 1);
    idle(2, 1);
    chk("bad_err_cnt", 32'(err_cnt[0]), 32'd1);
    chk("bad_no_evt", 32'(evt_valid[0]), 32'd0);
    step(1, 0, {8'hEF, 8'h10, 8'h34, 8'h12}, 1);
    chk("ext_strict_rej", 32'(evt_valid[0]), 32'd0);
    chk("ext_loose_press", 32'(evt_data[1]), 32'({2'b01, 8'h12, 8'h10}));
    chk("ext_strict_err", 32'(err_cnt[0]), 32'd2);
    idle(TO + 3, 1);

    // Key switch with a simultaneous repeat pulse.
    step(1, 0, mk(8'h01, 8'h10), 1);
    idle(5, 1);
    step(1, 1, mk(8'h01, 8'h20), 1);
    chk("switch_release", 32'(evt_data[0]), 32'({2'b11, 8'h01, 8'h10}));
    step(0, 1, '0, 1);
    chk("switch_press", 32'(evt_data[0]), 32'({2'b01, 8'h01, 8'h20}));
    idle(TO + 3, 1);

    // Stalled consumer: six events into a four-entry buffer.
    step(1, 0, mk(8'h01, 8'h01), 0);
    idle(1, 0);
    step(1, 0, mk(8'h01, 8'h02), 0);
    idle(1, 0);
    step(1, 0, mk(8'h01, 8'h03), 0);
    idle(TO + 3, 0);
    chk("stall_drop_cnt", 32'(drop_cnt[0]), 32'd2);
    chk("stall_head", 32'(evt_data[0]), 32'({2'b01, 8'h01, 8'h01}));
    idle(8, 1);

    // Randomized traffic: busy, sparse (timeouts), and heavy back-pressure.
    rand_phase(3000, 30, 120, 70);
    rand_phase(3000, 3, 8, 50);
    rand_phase(1000, 40, 150, 10);
    idle(TO + 10, 1);

    // Reset mid-operation with two events buffered in PRESSED.
    step(1, 0, mk(8'h05, 8'h06), 0);
    for (int i = 0; i < HE; i++) step(0, 1, '0, 0);
    compare_all();
    chk("pre_rst_keydown", 32'(key_down[0]), 32'd1);
    i_valid = 0; i_repeat = 0; i_frame = '0; i_evt_ready = 0;
    #2 rst = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_valid[%0d]", d), 32'(evt_valid[d]), 32'd0);
      chk($sformatf("rst_data[%0d]", d), 32'(evt_data[d]), 32'd0);
      chk($sformatf("rst_keydown[%0d]", d), 32'(key_down[d]), 32'd0);
      chk($sformatf("rst_err[%0d]", d), 32'(err_cnt[d]), 32'd0);
      chk($sformatf("rst_drop[%0d]", d), 32'(drop_cnt[d]), 32'd0);
      chk($sformatf("rst_state[%0d]", d), 32'(dbg_state[d]), 32'(ST_IDLE));
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(4, 1);
    step(1, 0, mk(8'h07, 8'h08), 1);
    idle(3, 1);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ir_key_ctrl.md
# ir_key_ctrl

Key-event controller between the NEC receiver (`ir_rx`) and its consumers. It validates each decoded frame and tracks key state across NEC repeat codes with a release timeout. It then emits PRESS / HOLD / RELEASE events through a small buffered valid/ready stream. It runs in the receiver's divided clock domain and replaces direct use of the raw frame bus by downstream logic.

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of address and command fields
- `TIMEOUT_CYC`, 120000, cycles without frame/repeat before RELEASE (120 ms at 1 MHz)
- `HOLD_EVERY`, 4, repeat codes per HOLD event (≥1)
- `STRICT_ADDR`, 1, 1: require address_bar == ~address; 0: accept extended (16-bit) addresses
- `FIFO_DEPTH`, 4, event buffer entries (power of two)

Ports:
- `clk`  in  1  receiver clock (divided clock)
- `rst`  in  1  asynchronous, active-high reset
- `i_valid`  in  1  one-cycle pulse, full frame decoded
- `i_repeat`  in  1  one-cycle pulse, NEC repeat code decoded
- `i_frame`  in  4*DATA_WIDTH  {command_bar, command, address_bar, address}
- `o_evt_valid`  out  1  event available
- `i_evt_ready`  in  1  consumer accepts event
- `o_evt_data`  out  2+2*DATA_WIDTH  {type[1:0], address, command}
- `o_key_down`  out  1  high while in PRESSED
- `o_err_cnt`  out  8  saturating count of rejected frames
- `o_drop_cnt`  out  8  saturating count of events lost to full FIFO

## Operation
- Frame check: command_bar must equal ~command; if STRICT_ADDR, address_bar must equal ~address. Failure: o_err_cnt++, frame discarded, state unchanged.
- Event types: 2'b01 PRESS, 2'b10 HOLD, 2'b11 RELEASE. Event address/command = latched current key.
- FSM states: IDLE, PRESSED, SWITCH.
  - IDLE: good frame -> latch key, push PRESS, clear timer and repeat count -> PRESSED. Repeat ignored.
  - PRESSED: repeat -> timer cleared, repeat count++; when count reaches HOLD_EVERY push HOLD and reset count to 0. Timer reaches TIMEOUT_CYC-1 -> push RELEASE -> IDLE. Good frame (same or different key) -> push RELEASE of old key, latch new key -> SWITCH.
  - SWITCH: push PRESS of new key, clear timer/count -> PRESSED. Inputs in this cycle are ignored.
- Simultaneous i_valid and i_repeat: valid wins, repeat discarded. Good frame on the timeout cycle: handled as a frame in PRESSED (RELEASE then PRESS). Bad frame on the timeout cycle: timeout proceeds.
- FIFO: at most one push per cycle. Push while full (and no pop that cycle) -> event dropped, o_drop_cnt++. State transitions occur regardless of drops. Push and pop together when full are both accepted.
- Counters saturate at 8'hFF. They clear only on reset.

## Timing
- Reset values: o_evt_valid 0, o_evt_data 0, o_key_down 0, o_err_cnt 0, o_drop_cnt 0; FSM IDLE, timer 0, FIFO empty.
- First-word fall-through FIFO, registered pointers. An event pushed at edge t is visible on o_evt_valid/o_evt_data after edge t (one-cycle latency from i_valid/i_repeat).
- Transfer on o_evt_valid & i_evt_ready at the rising edge. o_evt_data is stable while valid & !ready.
- SWITCH: RELEASE visible at t+1, PRESS written at t+2.
- o_key_down is registered and follows the FSM state (high in PRESSED and SWITCH).
- Reset asserted mid-operation: everything returns to reset values immediately and any pending event is lost.

## Structure
- Package `ir_pkg`: `evt_type_e` enum (PRESS/HOLD/RELEASE), `state_e` (IDLE/PRESSED/SWITCH), a localparam/function for event width 2+2*DATA_WIDTH.
- Sub-module `ir_evt_fifo`: parameterized synchronous FWFT FIFO with full/empty and async active-high reset. FSM, frame check, timer and counters stay in `ir_key_ctrl`.

## Test plan
- Good frame {8'hEF,8'h10,8'hFE,8'h01}, ready=1 -> PRESS {01,01,10} one cycle later. No activity for TIMEOUT_CYC cycles -> RELEASE {11,01,10}, o_key_down 0.
- PRESS then 8 repeats spaced 1000 cycles, HOLD_EVERY=4 -> exactly 2 HOLD events, no RELEASE until TIMEOUT_CYC after the last repeat.
- Frame with command_bar 8'h00, command 8'h10 -> no event, o_err_cnt=1. With STRICT_ADDR=0, address 8'h12/address_bar 8'h34 accepted -> PRESS.
- In PRESSED with key 0x10, good frame key 0x20 -> RELEASE(0x10) at t+1 and PRESS(0x20) at t+2 in order. i_valid with i_repeat in the same cycle -> repeat ignored.
- i_evt_ready=0, generate 6 events with FIFO_DEPTH=4 -> 4 retained in order, o_drop_cnt=2. Data stays stable while stalled.
- Assert rst while the FIFO holds 2 events in PRESSED -> all outputs and counters go to 0 asynchronously and the FSM returns to IDLE.
